// File: rtl/intt_butterfly_unit.sv
// Pipelined Gentleman-Sande butterfly for the Kyber inverse NTT.
// a' = (a + b) mod q, b' = ((a - b) * w) mod q, optionally halved mod q; six-cycle latency.
module intt_butterfly_unit #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned MODULUS    = 3329,
  parameter int unsigned BARRETT_K  = 5039
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] twiddle,
  input  logic                  scale_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = DATA_WIDTH + 1;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned BW = PW + 13;

  localparam logic [SW-1:0] Q_S = SW'(MODULUS);
  localparam logic [PW-1:0] Q_P = PW'(MODULUS);
  localparam logic [BW-1:0] K_B = BW'(BARRETT_K);

  // Multiply by 2^-1 mod q: odd values borrow one q before shifting.
  function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] x);
    logic [SW-1:0] t;
    t = SW'(x) + (x[0] ? Q_S : SW'(0));
    return DW'(t >> 1);
  endfunction

  logic [DW-1:0] a1_q, b1_q, w1_q;
  logic          sc1_q, v1_q;
  logic [DW-1:0] s2_q, d2_q, w2_q;
  logic          sc2_q, v2_q;
  logic [PW-1:0] p3_q;
  logic [DW-1:0] s3_q;
  logic          sc3_q, v3_q;
  logic [SW-1:0] r4_q;
  logic [DW-1:0] s4_q;
  logic          sc4_q, v4_q;
  logic [DW-1:0] r5_q, s5_q;
  logic          sc5_q, v5_q;

  logic [DW-1:0] s2_d, d2_d, r5_d, a_out_d, b_out_d;
  logic [PW-1:0] p3_d;
  logic [SW-1:0] r4_d;

  logic [SW-1:0] sum_c, dif_c, r_one_c, r_two_c;
  logic [BW-1:0] bar_c;
  logic [PW-1:0] t_c, r_full_c;

  // S2 modular add/sub, S3 multiply, S4 Barrett estimate, S5 final correction, S6 halving.
  always_comb begin
    sum_c    = SW'(a1_q) + SW'(b1_q);
    s2_d     = (sum_c >= Q_S) ? DW'(sum_c - Q_S) : DW'(sum_c);
    dif_c    = SW'(a1_q) - SW'(b1_q) + ((a1_q < b1_q) ? Q_S : SW'(0));
    d2_d     = DW'(dif_c);

    p3_d     = PW'(d2_q) * PW'(w2_q);

    bar_c    = BW'(p3_q) * K_B;
    t_c      = PW'(bar_c >> PW);
    r_full_c = p3_q - t_c * Q_P;
    r4_d     = SW'(r_full_c);

    r_one_c  = (r4_q >= Q_S) ? r4_q - Q_S : r4_q;
    r_two_c  = (r_one_c >= Q_S) ? r_one_c - Q_S : r_one_c;
    r5_d     = DW'(r_two_c);

    a_out_d  = sc5_q ? half_mod(s5_q) : s5_q;
    b_out_d  = sc5_q ? half_mod(r5_q) : r5_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q <= '0; b1_q <= '0; w1_q <= '0; sc1_q <= 1'b0; v1_q <= 1'b0;
      s2_q <= '0; d2_q <= '0; w2_q <= '0; sc2_q <= 1'b0; v2_q <= 1'b0;
      p3_q <= '0; s3_q <= '0; sc3_q <= 1'b0; v3_q <= 1'b0;
      r4_q <= '0; s4_q <= '0; sc4_q <= 1'b0; v4_q <= 1'b0;
      r5_q <= '0; s5_q <= '0; sc5_q <= 1'b0; v5_q <= 1'b0;
      a_out <= '0; b_out <= '0; valid_out <= 1'b0;
    end else if (enable) begin
      a1_q <= a_in; b1_q <= b_in; w1_q <= twiddle; sc1_q <= scale_in; v1_q <= valid_in;
      s2_q <= s2_d; d2_q <= d2_d; w2_q <= w1_q; sc2_q <= sc1_q; v2_q <= v1_q;
      p3_q <= p3_d; s3_q <= s2_q; sc3_q <= sc2_q; v3_q <= v2_q;
      r4_q <= r4_d; s4_q <= s3_q; sc4_q <= sc3_q; v4_q <= v3_q;
      r5_q <= r5_d; s5_q <= s4_q; sc5_q <= sc4_q; v5_q <= v4_q;
      a_out <= a_out_d; b_out <= b_out_d; valid_out <= v5_q;
    end
  end

  assign busy = v1_q | v2_q | v3_q | v4_q | v5_q | valid_out;

endmodule

// File: tb/tb_intt_butterfly_unit.sv
// Directed bench for intt_butterfly_unit with hand-computed expected results.
module tb_intt_butterfly_unit;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          rst, enable, valid_in, scale_in;
  logic [DW-1:0] a_in, b_in, twiddle, a_out, b_out;
  logic          valid_out, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int got_a[$], got_b[$], got_t[$];

  always #5 clk = ~clk;

  intt_butterfly_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .twiddle(twiddle), .scale_in(scale_in),
    .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. Only advancing edges are logged.
  task automatic tick();
    logic en;
    en = enable;
    @(posedge clk);
    #1;
    cyc++;
    if (en && !rst && valid_out) begin
      got_a.push_back(int'(a_out));
      got_b.push_back(int'(b_out));
      got_t.push_back(cyc);
    end
  endtask

  task automatic send(input int a, input int b, input int w, input logic sc);
    enable = 1'b1; valid_in = 1'b1;
    a_in = DW'(a); b_in = DW'(b); twiddle = DW'(w); scale_in = sc;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n, input int bound);
    int k;
    enable = 1'b1; valid_in = 1'b0;
    k = 0;
    while (got_a.size() < n && k < bound) begin
      tick();
      k++;
    end
    if (got_a.size() < n) check("drain_timeout", got_a.size(), n);
  endtask

  task automatic clear_log();
    got_a.delete(); got_b.delete(); got_t.delete();
  endtask

  // Vectors: a, b, w, scale, expected a_out, expected b_out
  int vec[9][6] = '{
    '{3328,    1,    1, 0,    0, 3327},
    '{   0,    1,    1, 0,    1, 3328},
    '{3328,    0, 3328, 0, 3328,    1},
    '{   1,    0,    1, 1, 1665, 1665},
    '{ 100,  200, 1000, 0,  300, 3199},
    '{   4,    2,    3, 1,    3,    3},
    '{2000, 1500,    2, 1, 1750,  500},
    '{3000, 3000,    5, 0, 2671,    0},
    '{3328,    1, 3328, 0,    0,    2}
  };

  initial begin
    int t0;
    rst = 1'b1; enable = 1'b0; valid_in = 1'b1; scale_in = 1'b1;
    a_in = 12'd77; b_in = 12'd55; twiddle = 12'd9;

    // Reset wins over enable=0
    tick(); tick();
    check("rst_a_out", a_out, 0);
    check("rst_b_out", b_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; valid_in = 1'b0; scale_in = 1'b0;

    // Single token latency and busy
    clear_log();
    send(5, 3, 17, 1'b0);
    t0 = cyc;
    check("single_busy", busy, 1);
    drain(1, 20);
    if (got_a.size() >= 1) begin
      check("single_latency", got_t[0] - t0, 5);
      check("single_a", got_a[0], 8);
      check("single_b", got_b[0], 34);
    end
    tick();
    check("single_valid_pulse", valid_out, 0);
    check("single_busy_drop", busy, 0);

    // Back-to-back directed vectors, mixed scaling
    clear_log();
    for (int i = 0; i < 9; i++) begin
      send(vec[i][0], vec[i][1], vec[i][2], vec[i][3] != 0);
      if (i == 0) t0 = cyc;
    end
    drain(9, 40);
    for (int i = 0; i < 9 && i < got_a.size(); i++) begin
      check($sformatf("vec%0d_a", i), got_a[i], vec[i][4]);
      check($sformatf("vec%0d_b", i), got_b[i], vec[i][5]);
      check($sformatf("vec%0d_time", i), got_t[i] - t0, 5 + i);
    end

    // Bubble between two tokens
    clear_log();
    send(7, 7, 7, 1'b0);
    t0 = cyc;
    tick();
    send(9, 1, 4, 1'b0);
    drain(2, 20);
    if (got_a.size() >= 2) begin
      check("bubble_a0", got_a[0], 14);
      check("bubble_b0", got_b[0], 0);
      check("bubble_a1", got_a[1], 10);
      check("bubble_b1", got_b[1], 32);
      check("bubble_gap", got_t[1] - got_t[0], 2);
    end

    // 8-token stream with a 3-cycle stall after the 4th input; stalled inputs are garbage
    clear_log();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        enable = 1'b0; valid_in = 1'b1;
        a_in = 12'd999; b_in = 12'd1; twiddle = 12'd5; scale_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          check("stall_valid_hold", valid_out, 0);
          check("stall_busy", busy, 1);
        end
      end
      send(10 * i + 1, i, 2, 1'b0);
      if (i == 0) t0 = cyc;
    end
    drain(8, 40);
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      check($sformatf("stall%0d_a", i), got_a[i], 11 * i + 1);
      check($sformatf("stall%0d_b", i), got_b[i], 18 * i + 2);
    end
    // First input cycle counts as cycle 1 of the 8+3+5
    if (got_t.size() >= 8) check("stall_last_time", got_t[7] - t0 + 1, 8 + 3 + 5);

    // Stall while a result is on the outputs: data and valid must hold
    clear_log();
    send(11, 22, 3, 1'b0);
    send(50, 60, 1, 1'b1);
    send(1, 1, 9, 1'b0);
    drain(1, 20);
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("hold_valid", valid_out, 1);
      check("hold_a", a_out, 33);
      check("hold_b", b_out, 3296);
    end
    drain(3, 20);
    if (got_a.size() >= 3) begin
      check("hold_a0", got_a[0], 33);
      check("hold_b0", got_b[0], 3296);
      check("hold_a1", got_a[1], 55);
      check("hold_b1", got_b[1], 3324);
      check("hold_a2", got_a[2], 2);
      check("hold_b2", got_b[2], 0);
    end

    // Reset with 4 tokens in flight
    clear_log();
    for (int i = 0; i < 4; i++) send(i + 1, 0, 1, 1'b0);
    rst = 1'b1; valid_in = 1'b1; enable = 1'b1;
    tick();
    check("midrst_valid", valid_out, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0; valid_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("midrst_stale", valid_out, 0);
    end
    check("midrst_outputs_seen", got_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
